mem_access_unit: RTL and testbench

- Data-memory access stage directly downstream of the execute unit.
- Consumes the ALU result as the effective address, rs2 data as store data, and funct3 as access width/sign.
- Runs a req/ack transaction on a word-wide data bus, then returns extended load data.
- Stalls the single-cycle core via `busy` until the access completes.

---
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory stage running a req/ack bus transaction and stalling the core via busy.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two aligned transactions instead of faulting.
module mem_access_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] alu_result,
    input  logic [XLEN-1:0]       store_data,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       load_data,
    output logic                  fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [XLEN-1:0]       bus_wdata,
    input  logic                  bus_ack,
    input  logic [XLEN-1:0]       bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ1, REQ2, RESP} state_t;
    state_t state;
    logic accept, legal_f3, misaligned, err;
    logic [1:0] off, off_q;
    logic [2:0] f3_q;
    logic [7:0] mask;
    logic [XLEN-1:0] rep, rsh;
    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] w, input logic [2:0] f);
        return f[1] ? w : f[0] ? {{(XLEN-16){w[15] & ~f[2]}}, w[15:0]}
                               : {{(XLEN-8){w[7] & ~f[2]}}, w[7:0]};
    endfunction
    assign off        = alu_result[1:0];
    assign accept     = ex_valid & (mem_read | mem_write);
    assign legal_f3   = (funct3[1:0] != 2'b11) & ~(funct3[2] & (mem_write | funct3[1]));
    assign mask       = {4'b0, (funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 : 4'b0001)} << off;
    assign misaligned = |mask[7:4];
    assign rep        = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    assign rsh        = bus_rdata >> {off_q, 3'b000};
    assign busy       = rst & ((state == IDLE & accept) | state == REQ1 | state == REQ2);
`ifdef MISALIGN_SPLIT_EN
    logic split_q;
    logic [3:0] be2_q;
    logic [XLEN-1:0] wd2_q, word0_q;
    logic [2*XLEN-1:0] wide, pair;
    assign err  = (mem_read & mem_write) | ~legal_f3;
    assign wide = {{XLEN{1'b0}}, store_data} << {off, 3'b000};
    assign pair = {bus_rdata, word0_q} >> {off_q, 3'b000};
`else
    assign err  = (mem_read & mem_write) | ~legal_f3 | misaligned;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            load_data <= '0;
            off_q     <= '0;
            f3_q      <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q   <= 1'b0;
            be2_q     <= '0;
            wd2_q     <= '0;
            word0_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    off_q  <= off;
                    f3_q   <= funct3;
                    bus_we <= mem_write;
                    fault  <= err;
                    if (err) begin
                        state <= RESP;
                        done  <= 1'b1;
                        if (mem_read) load_data <= '0;
                    end else begin
                        state    <= REQ1;
                        bus_req  <= 1'b1;
                        bus_addr <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                        bus_be   <= mask[3:0];
`ifdef MISALIGN_SPLIT_EN
                        bus_wdata <= misaligned ? wide[XLEN-1:0] : rep;
                        split_q   <= misaligned;
                        be2_q     <= mask[7:4];
                        wd2_q     <= wide[2*XLEN-1:XLEN];
`else
                        bus_wdata <= rep;
`endif
                    end
                end
                REQ1: if (bus_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state     <= REQ2;
                        word0_q   <= bus_rdata;
                        bus_addr  <= bus_addr + ADDR_WIDTH'(4);
                        bus_be    <= be2_q;
                        bus_wdata <= wd2_q;
                    end else
`endif
                    begin
                        state   <= RESP;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        if (!bus_we) load_data <= ext(rsh, f3_q);
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                REQ2: if (bus_ack) begin
                    state   <= RESP;
                    bus_req <= 1'b0;
                    done    <= 1'b1;
                    if (!bus_we) load_data <= ext(pair[XLEN-1:0], f3_q);
                end
`endif
                RESP: begin
                    state <= IDLE;
                    fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-vector bench for mem_access_unit in its default (non-split) build.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] alu_result = '0, store_data = '0;
    logic        busy, done, fault, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    int n_tests = 0, n_fail = 0;
    logic        saw_req, req_we, busy_ok, seen;
    logic [31:0] req_addr, req_wd;
    logic [3:0]  req_be;
    int          done_cyc;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept at cycle 0, ack dly cycles after the first bus_req cycle; done_cyc is the cycle done was seen.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int dly, input logic [31:0] rdata);
        int rq;
        saw_req = 1'b0; busy_ok = 1'b1; done_cyc = -1; rq = -1;
        req_addr = '0; req_be = '0; req_wd = '0; req_we = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a; store_data = sd;
        for (int c = 0; c < 20 && done_cyc < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                ex_valid = 1'b0;
            end
            if (bus_req && !saw_req) begin
                saw_req = 1'b1; rq = c;
                req_addr = bus_addr; req_be = bus_be; req_wd = bus_wdata; req_we = bus_we;
            end
            bus_ack   = bus_req && (c == rq + dly);
            bus_rdata = rdata;
            #1;
            if (done) begin
                done_cyc = c;
                if (busy) busy_ok = 1'b0;
            end else if (!busy) busy_ok = 1'b0;
        end
        bus_ack = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_load_data", load_data, 0);
        check("rst_bus_addr", bus_addr, 0);
        rst = 1'b1;

        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        check("sw_req", saw_req, 1);
        check("sw_we", req_we, 1);
        check("sw_addr", req_addr, 32'h100);
        check("sw_be", req_be, 4'hF);
        check("sw_wdata", req_wd, 32'hDEADBEEF);
        check("sw_done_cyc", done_cyc, 4);
        check("sw_busy", busy_ok, 1);
        check("sw_fault", fault, 0);
        @(posedge clk); #1;
        check("sw_done_pulse", done, 0);

        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
        check("lb_be", req_be, 4'h8);
        check("lb_addr", req_addr, 32'h100);
        check("lb_data", load_data, 32'hFFFFFF80);
        check("lb_done_cyc", done_cyc, 2);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233);
        check("lbu_data", load_data, 32'h00000080);

        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h0);
        check("sh_be", req_be, 4'hC);
        check("sh_wdata", req_wd, 32'hABCDABCD);
        check("sh_done_cyc", done_cyc, 2);
        check("sh_busy", busy_ok, 1);

        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233);
        check("lh_data", load_data, 32'hFFFF8011);
        check("lh_done_cyc", done_cyc, 3);
        do_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h80118233);
        check("lhu_data", load_data, 32'h00008233);
        check("lhu_be", req_be, 4'h3);

        do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h12345678);
        check("lw_data", load_data, 32'h12345678);
        check("lw_addr", req_addr, 32'h104);

        do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000005A, 0, 32'h0);
        check("sb_be", req_be, 4'h2);
        check("sb_wdata", req_wd, 32'h5A5A5A5A);
        check("sb_hold_load", load_data, 32'h12345678);

        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        check("mis_fault", fault, 1);
        check("mis_done_cyc", done_cyc, 1);
        check("mis_no_req", saw_req, 0);
        check("mis_load_zero", load_data, 0);

        do_access(1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 0, 32'h0);
        check("rw_fault", fault, 1);
        check("rw_done_cyc", done_cyc, 1);
        check("rw_no_req", saw_req, 0);

        do_access(1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 0, 32'h0);
        check("f3_fault", fault, 1);
        check("f3_no_req", saw_req, 0);
        @(posedge clk); #1;
        check("f3_fault_clear", fault, 0);

        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h100;
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_read = 1'b0;
        check("ar_pre_req", bus_req, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_req_drop", bus_req, 0);
        check("ar_busy_drop", busy, 0);
        check("ar_done_drop", done, 0);
        bus_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || bus_req || busy) seen = 1'b1;
        end
        bus_ack = 1'b0;
        check("ar_late_ack", seen, 0);

        do_access(1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 0, 32'h000000A5);
        check("post_rst_data", load_data, 32'h000000A5);
        check("post_rst_done_cyc", done_cyc, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
